// File: rtl/ar_demux_dispatch_pkg.sv
// rtl/ar_demux_dispatch_pkg.sv - shared constants and state encoding for the demux dispatcher
package ar_demux_pkg;

  localparam int NUM_CH = 4;
  localparam int SEL_W  = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } state_t;

  function automatic int max2(input int x, input int y);
    return (x > y) ? x : y;
  endfunction

endpackage

// File: rtl/ar_demux_dispatch_if.sv
// rtl/ar_demux_dispatch_if.sv - serial input handshake, channel readiness and demux drive signals
interface ar_demux_dispatch_if;
  import ar_demux_pkg::*;

  logic              in_bit;
  logic              in_valid;
  logic              in_ready;
  logic [NUM_CH-1:0] ch_ready;
  logic              a;
  logic [SEL_W-1:0]  sel;
  logic              enable;
  logic              burst_done;

  // master is the stream/sink side, slave is the dispatcher
  modport master (
    output in_bit, in_valid, ch_ready,
    input  in_ready, a, sel, enable, burst_done
  );

  modport slave (
    input  in_bit, in_valid, ch_ready,
    output in_ready, a, sel, enable, burst_done
  );

endinterface

// File: rtl/ar_rr_arb4.sv
// rtl/ar_rr_arb4.sv - combinational 4-way round-robin arbiter starting after the last grant
module ar_rr_arb4
  import ar_demux_pkg::*;
(
  input  logic [NUM_CH-1:0] req,
  input  logic [SEL_W-1:0]  last,
  output logic [SEL_W-1:0]  gnt_idx,
  output logic              gnt_any
);

  logic [SEL_W-1:0] idx;

  // offset NUM_CH wraps back to last itself, so a lone requester is regranted
  always_comb begin
    gnt_idx = '0;
    gnt_any = 1'b0;
    idx     = '0;
    for (int i = 1; i <= NUM_CH; i++) begin
      idx = last + SEL_W'(i);
      if (!gnt_any && req[idx]) begin
        gnt_idx = idx;
        gnt_any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ar_demux_dispatch.sv
// rtl/ar_demux_dispatch.sv - round-robin burst dispatcher driving a combinational 1:4 demux
module ar_demux_dispatch
  import ar_demux_pkg::*;
#(
  parameter int BURST_LEN  = 8,
  parameter int GAP_CYCLES = 1
)
(
  input  logic          clk,
  input  logic          rst,
  ar_demux_dispatch_if.slave bus
);

  localparam int CNT_W = $clog2(max2(BURST_LEN, GAP_CYCLES + 1)) + 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(BURST_LEN - 1);
  localparam logic [CNT_W-1:0] LAST_GAP = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  state_t           state, state_d;
  logic [CNT_W-1:0] count, count_d;
  logic [SEL_W-1:0] last, last_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic             a_q, a_d;
  logic             en_q, en_d;
  logic             done_q, done_d;
  logic [SEL_W-1:0] gnt_idx;
  logic             gnt_any;
  logic             xfer;

  ar_rr_arb4 u_arb (
    .req     (bus.ch_ready),
    .last    (last),
    .gnt_idx (gnt_idx),
    .gnt_any (gnt_any)
  );

  assign bus.in_ready   = (state == SEND) && bus.ch_ready[sel_q];
  assign xfer           = bus.in_valid && bus.in_ready;
  assign bus.a          = a_q;
  assign bus.sel        = sel_q;
  assign bus.enable     = en_q;
  assign bus.burst_done = done_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      count  <= '0;
      last   <= '1;
      sel_q  <= '0;
      a_q    <= 1'b0;
      en_q   <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state  <= state_d;
      count  <= count_d;
      last   <= last_d;
      sel_q  <= sel_d;
      a_q    <= a_d;
      en_q   <= en_d;
      done_q <= done_d;
    end
  end

  // enable and burst_done are strobes: they default low every cycle
  always_comb begin
    state_d = state;
    count_d = count;
    last_d  = last;
    sel_d   = sel_q;
    a_d     = a_q;
    en_d    = 1'b0;
    done_d  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.in_valid && gnt_any) begin
          sel_d   = gnt_idx;
          count_d = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        if (xfer) begin
          a_d  = bus.in_bit;
          en_d = 1'b1;
          if (count == LAST_BIT) begin
            last_d  = sel_q;
            done_d  = 1'b1;
            count_d = '0;
            state_d = (GAP_CYCLES == 0) ? IDLE : GAP;
          end else begin
            count_d = count + CNT_W'(1);
          end
        end
      end
      GAP: begin
        if (count == LAST_GAP) begin
          count_d = '0;
          state_d = IDLE;
        end else begin
          count_d = count + CNT_W'(1);
        end
      end
      default: begin
        count_d = '0;
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_ar_demux_dispatch.sv
// tb/tb_ar_demux_dispatch.sv - directed self-checking bench for the round-robin demux dispatcher
module tb_ar_demux_dispatch;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  ar_demux_dispatch_if bus8();
  ar_demux_dispatch_if bus1();

  ar_demux_dispatch #(.BURST_LEN(8), .GAP_CYCLES(1)) dut8 (
    .clk (clk),
    .rst (rst),
    .bus (bus8)
  );

  ar_demux_dispatch #(.BURST_LEN(1), .GAP_CYCLES(0)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  // downstream demux as a reference: y[sel] = a while enabled
  logic [3:0] y8;
  assign y8 = bus8.enable ? ((4'b0001 << bus8.sel) & {4{bus8.a}}) : 4'b0000;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus8.ch_ready = 4'b0000; bus8.in_valid = 1'b0; bus8.in_bit = 1'b0;
    bus1.ch_ready = 4'b0000; bus1.in_valid = 1'b0; bus1.in_bit = 1'b0;
    tick();
    n_checks++;
    if ({bus8.a, bus8.sel, bus8.enable, bus8.burst_done, bus8.in_ready} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_state: got %b required 000000",
               {bus8.a, bus8.sel, bus8.enable, bus8.burst_done, bus8.in_ready});
    end
    bus8.ch_ready = 4'b1111; bus8.in_valid = 1'b1; bus8.in_bit = 1'b1;
    rst = 1'b0;
    repeat (13) tick();
    n_checks++;
    if ({bus8.a, bus8.sel, bus8.enable} !== 4'b1011) begin
      n_fail++;
      $display("FAIL reset_pre_midburst: got a,sel,en=%b required 1011", {bus8.a, bus8.sel, bus8.enable});
    end
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if ({bus8.a, bus8.sel, bus8.enable} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_async: got a,sel,en=%b required 0000", {bus8.a, bus8.sel, bus8.enable});
    end
    tick();
    tick();
    rst = 1'b0;
    tick();
    tick();
    n_checks++;
    if ({bus8.sel, bus8.enable} !== 3'b001) begin
      n_fail++;
      $display("FAIL reset_first_grant: got sel,en=%b required 001", {bus8.sel, bus8.enable});
    end
  endtask

  task automatic test_round_robin();
    bus8.ch_ready = 4'b1111; bus8.in_valid = 1'b1; bus8.in_bit = 1'b0;
    apply_reset();
    for (int c = 1; c <= 50; c++) begin
      int  m;
      logic exp_en;
      logic exp_done;
      tick();
      m        = c % 10;
      exp_en   = (m >= 2);
      exp_done = (m == 9);
      n_checks++;
      if (bus8.enable !== exp_en || bus8.burst_done !== exp_done) begin
        n_fail++;
        $display("FAIL rr_strobes cycle %0d: got en=%b done=%b required en=%b done=%b",
                 c, bus8.enable, bus8.burst_done, exp_en, exp_done);
      end
      if (m == 5) begin
        n_checks++;
        if (bus8.sel !== 2'((c / 10) % 4)) begin
          n_fail++;
          $display("FAIL rr_sel burst %0d: got %0d required %0d", c / 10, bus8.sel, (c / 10) % 4);
        end
      end
    end
  endtask

  task automatic test_skip_wrap();
    bus8.ch_ready = 4'b1001; bus8.in_valid = 1'b1;
    apply_reset();
    for (int c = 1; c <= 40; c++) begin
      tick();
      if (c % 10 == 5) begin
        n_checks++;
        if (bus8.sel !== (((c / 10) % 2 == 1) ? 2'd3 : 2'd0)) begin
          n_fail++;
          $display("FAIL skip_1001 burst %0d: got sel=%0d", c / 10, bus8.sel);
        end
      end
    end
    bus8.ch_ready = 4'b0100;
    apply_reset();
    for (int c = 1; c <= 40; c++) begin
      tick();
      if (c % 10 == 5) begin
        n_checks++;
        if (bus8.sel !== 2'd2 || bus8.enable !== 1'b1) begin
          n_fail++;
          $display("FAIL single_0100 burst %0d: got sel=%0d en=%b required sel=2 en=1",
                   c / 10, bus8.sel, bus8.enable);
        end
      end
    end
  endtask

  task automatic test_idle_hold();
    bus8.ch_ready = 4'b1111; bus8.in_valid = 1'b0;
    apply_reset();
    repeat (5) tick();
    n_checks++;
    if ({bus8.in_ready, bus8.enable, bus8.sel} !== 4'b0000) begin
      n_fail++;
      $display("FAIL idle_no_valid: got rdy,en,sel=%b required 0000", {bus8.in_ready, bus8.enable, bus8.sel});
    end
    bus8.ch_ready = 4'b0010;
    bus8.in_valid = 1'b1;
    #1;
    n_checks++;
    if (bus8.in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_in_ready: got %b required 0", bus8.in_ready);
    end
    tick();
    n_checks++;
    if (bus8.sel !== 2'd1 || bus8.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL idle_same_cycle_grant: got sel=%0d rdy=%b required sel=1 rdy=1", bus8.sel, bus8.in_ready);
    end
  endtask

  task automatic test_pause();
    logic [7:0] pat;
    pat = 8'b1010_0101;
    bus8.ch_ready = 4'b1111; bus8.in_valid = 1'b1; bus8.in_bit = 1'b0;
    apply_reset();
    tick();
    for (int i = 0; i < 4; i++) begin
      bus8.in_bit = pat[i];
      tick();
      n_checks++;
      if (bus8.enable !== 1'b1 || bus8.a !== pat[i]) begin
        n_fail++;
        $display("FAIL pause_pre bit %0d: got en=%b a=%b required en=1 a=%b", i, bus8.enable, bus8.a, pat[i]);
      end
    end
    bus8.ch_ready = 4'b1110;
    for (int j = 0; j < 5; j++) begin
      #1;
      n_checks++;
      if (bus8.in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL pause_in_ready cycle %0d: got %b required 0", j, bus8.in_ready);
      end
      tick();
      n_checks++;
      if ({bus8.enable, bus8.burst_done, bus8.sel} !== 4'b0000) begin
        n_fail++;
        $display("FAIL pause_hold cycle %0d: got en,done,sel=%b required 0000",
                 j, {bus8.enable, bus8.burst_done, bus8.sel});
      end
    end
    bus8.ch_ready = 4'b1111;
    for (int i = 4; i < 8; i++) begin
      bus8.in_bit = pat[i];
      tick();
      n_checks++;
      if (bus8.enable !== 1'b1 || bus8.a !== pat[i] || bus8.sel !== 2'd0 ||
          bus8.burst_done !== (i == 7)) begin
        n_fail++;
        $display("FAIL pause_resume bit %0d: got en=%b a=%b sel=%0d done=%b", i,
                 bus8.enable, bus8.a, bus8.sel, bus8.burst_done);
      end
    end
  endtask

  task automatic test_data_path();
    logic [7:0] pat;
    logic       exp_a [8];
    int         acc;
    int         n;
    logic       accept;
    pat   = 8'b1011_0010;
    exp_a = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    acc   = 0;
    n     = 0;
    bus8.ch_ready = 4'b0100; bus8.in_valid = 1'b1; bus8.in_bit = 1'b0;
    apply_reset();
    for (int c = 0; c < 30 && n < 8; c++) begin
      if (bus8.enable === 1'b1) begin
        n_checks++;
        if (bus8.a !== exp_a[n] || y8 !== {1'b0, exp_a[n], 2'b00}) begin
          n_fail++;
          $display("FAIL data bit %0d: got a=%b y=%b required a=%b y=%b", n, bus8.a, y8,
                   exp_a[n], {1'b0, exp_a[n], 2'b00});
        end
        n++;
      end
      bus8.in_bit = (acc < 8) ? pat[acc[2:0]] : 1'b0;
      #1;
      accept = bus8.in_ready && bus8.in_valid;
      tick();
      if (accept) acc++;
    end
    n_checks++;
    if (n != 8) begin
      n_fail++;
      $display("FAIL data_count: got %0d strobes required 8", n);
    end
  endtask

  task automatic test_params();
    bus8.ch_ready = 4'b0000; bus8.in_valid = 1'b0;
    bus1.ch_ready = 4'b1111; bus1.in_valid = 1'b1; bus1.in_bit = 1'b1;
    apply_reset();
    for (int c = 1; c <= 16; c++) begin
      logic even;
      tick();
      even = (c % 2 == 0);
      n_checks++;
      if (bus1.enable !== even || bus1.burst_done !== even || bus1.in_ready !== !even) begin
        n_fail++;
        $display("FAIL len1_timing cycle %0d: got en=%b done=%b rdy=%b", c,
                 bus1.enable, bus1.burst_done, bus1.in_ready);
      end
      if (even) begin
        n_checks++;
        if (bus1.sel !== 2'((c / 2 - 1) % 4)) begin
          n_fail++;
          $display("FAIL len1_sel cycle %0d: got %0d required %0d", c, bus1.sel, (c / 2 - 1) % 4);
        end
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_round_robin();
    test_skip_wrap();
    test_idle_hold();
    test_pause();
    test_data_path();
    test_params();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
